// File: rtl/analog_tx_pkg.sv
// Shared types and helpers for the analog spin transmitter.
//   tx_state_e     : capture FSM states
//   tx_mode_e      : one-shot vs continuous capture
//   vote_cnt_width : width of a per-bit vote counter able to hold 0..max_samples
package analog_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    PUSH   = 2'd3
  } tx_state_e;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_CONT    = 1'b1
  } tx_mode_e;

  function automatic int unsigned vote_cnt_width(input int unsigned max_samples);
    return $clog2(max_samples + 1);
  endfunction

endpackage

// File: rtl/spin_fifo.sv
// First-word-fall-through queue with registered head outputs.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : synchronous clear of all entries (wins over push/pop)
//   push_i/data_i : write request and data; accepted when not full or when
//                   a pop happens in the same cycle
//   full_o        : all DEPTH entries occupied
//   pop_i         : consumer ready; pops only while valid_o is high
//   valid_o/data_o: registered head of queue (data_o is zero while empty)
module spin_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] head_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o = (count == CW'(DEPTH));

  // The head register is loaded with the entry that will be at the head
  // after this edge, so data_o/valid_o come straight from flops.
  always_comb begin
    do_pop     = pop_i & valid_o;
    do_push    = push_i & (~full_o | do_pop);
    rd_ptr_nxt = do_pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_nxt = do_push ? ptr_inc(wr_ptr) : wr_ptr;
    count_nxt  = count + CW'(do_push) - CW'(do_pop);
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (do_push && (count == CW'(do_pop))) begin
      // queue was (or becomes) empty before this write: new data is the head
      head_nxt = data_i;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      valid_o <= (count_nxt != '0);
      data_o  <= head_nxt;
    end
  end

endmodule

// File: rtl/analog_tx_vote.sv
// Analog-to-digital spin transmitter with settle delay and per-bit majority vote.
// After a computation-finished edge (or continuously in mode 1) it waits D
// settle cycles, samples spin_i for N cycles, votes each bit and queues the
// result toward the digital core.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   en_i               : block enable; low aborts capture and flushes the queue
//   cfg_we_i           : config write strobe (honoured only while IDLE and enabled)
//   cfg_delay_i        : settle cycles D
//   cfg_samples_i      : vote count N (0 -> 1, above MAX_SAMPLES -> MAX_SAMPLES)
//   cfg_mode_i         : 0 one-shot per finish edge, 1 continuous
//   spin_i             : raw spins from the analog macro
//   cmpt_finish_i      : analog computation-finished level
//   spin_valid_o/spin_ready_i/spin_o : output queue handshake and head data
//   drop_o             : one-cycle pulse, registered, after a PUSH that found the queue full
//   idle_o             : FSM idle and queue empty
module analog_tx_vote
  import analog_tx_pkg::*;
#(
  parameter  int unsigned NUM_SPIN    = 256,
  parameter  int unsigned DELAY_W     = 8,
  parameter  int unsigned MAX_SAMPLES = 5,
  parameter  int unsigned FIFO_DEPTH  = 2,
  localparam int unsigned SW          = vote_cnt_width(MAX_SAMPLES)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                cfg_we_i,
  input  logic [DELAY_W-1:0]  cfg_delay_i,
  input  logic [SW-1:0]       cfg_samples_i,
  input  logic                cfg_mode_i,
  input  logic [NUM_SPIN-1:0] spin_i,
  input  logic                cmpt_finish_i,
  output logic                spin_valid_o,
  input  logic                spin_ready_i,
  output logic [NUM_SPIN-1:0] spin_o,
  output logic                drop_o,
  output logic                idle_o
);

  tx_state_e                     state;
  tx_mode_e                      mode_q;
  logic [DELAY_W-1:0]            delay_q;
  logic [SW-1:0]                 n_q;
  logic [SW-1:0]                 n_wr;
  logic                          finish_q;
  logic                          fin_pulse;
  logic [DELAY_W-1:0]            settle_cnt;
  logic [SW-1:0]                 samp_left;
  logic [NUM_SPIN-1:0][SW-1:0]   vote_cnt;
  logic [NUM_SPIN-1:0][SW-1:0]   cnt_inc;
  logic [NUM_SPIN-1:0]           voted;
  logic                          fifo_full;
  logic                          pop_ok;

  assign fin_pulse = cmpt_finish_i & ~finish_q;
  assign pop_ok    = spin_valid_o & spin_ready_i;
  assign idle_o    = (state == IDLE) & ~spin_valid_o;

  always_comb begin
    if (cfg_samples_i == '0) begin
      n_wr = SW'(1);
    end else if (cfg_samples_i > SW'(MAX_SAMPLES)) begin
      n_wr = SW'(MAX_SAMPLES);
    end else begin
      n_wr = cfg_samples_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      delay_q  <= '0;
      n_q      <= SW'(1);
      mode_q   <= MODE_ONESHOT;
      finish_q <= 1'b0;
    end else begin
      if (en_i) begin
        finish_q <= cmpt_finish_i;
      end
      if (cfg_we_i && en_i && (state == IDLE)) begin
        delay_q <= cfg_delay_i;
        n_q     <= n_wr;
        mode_q  <= tx_mode_e'(cfg_mode_i);
      end
    end
  end

  // Saturating per-bit accumulate and vote; 2*cnt > N makes an even tie vote 0.
  always_comb begin
    cnt_inc = vote_cnt;
    voted   = '0;
    for (int unsigned b = 0; b < NUM_SPIN; b++) begin
      if (vote_cnt[b] != SW'(MAX_SAMPLES)) begin
        cnt_inc[b] = vote_cnt[b] + SW'(spin_i[b]);
      end
      voted[b] = ({vote_cnt[b], 1'b0} > {1'b0, n_q});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      settle_cnt <= '0;
      samp_left  <= '0;
      vote_cnt   <= '0;
      drop_o     <= 1'b0;
    end else if (!en_i) begin
      state      <= IDLE;
      settle_cnt <= '0;
      samp_left  <= '0;
      vote_cnt   <= '0;
      drop_o     <= 1'b0;
    end else begin
      drop_o <= 1'b0;
      case (state)
        IDLE: begin
          if ((mode_q == MODE_CONT) || fin_pulse) begin
            if (delay_q == '0) begin
              state     <= SAMPLE;
              samp_left <= n_q - SW'(1);
              vote_cnt  <= '0;
            end else begin
              state      <= SETTLE;
              settle_cnt <= delay_q - DELAY_W'(1);
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state     <= SAMPLE;
            samp_left <= n_q - SW'(1);
            vote_cnt  <= '0;
          end else begin
            settle_cnt <= settle_cnt - DELAY_W'(1);
          end
        end
        SAMPLE: begin
          vote_cnt <= cnt_inc;
          if (samp_left == '0) begin
            state <= PUSH;
          end else begin
            samp_left <= samp_left - SW'(1);
          end
        end
        PUSH: begin
          drop_o <= fifo_full & ~pop_ok;
          if (mode_q == MODE_CONT) begin
            if (delay_q == '0) begin
              state     <= SAMPLE;
              samp_left <= n_q - SW'(1);
              vote_cnt  <= '0;
            end else begin
              state      <= SETTLE;
              settle_cnt <= delay_q - DELAY_W'(1);
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spin_fifo #(
    .WIDTH (NUM_SPIN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (~en_i),
    .push_i  (state == PUSH),
    .data_i  (voted),
    .full_o  (fifo_full),
    .pop_i   (spin_ready_i),
    .valid_o (spin_valid_o),
    .data_o  (spin_o)
  );

endmodule
